// File: rtl/rv32i_types.sv
// rv32i_types: shared line/beat geometry and arbiter state encoding.
package rv32i_types;
    localparam int LINE_W    = 256;
    localparam int BEAT_W    = 64;
    localparam int BURST_LEN = 4;
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, DONE} mem_arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: I-cache, D-cache and burst-memory signals seen by the arbiter.
interface mem_arbiter_if;
    import rv32i_types::*;
    logic [31:0]       i_addr;
    logic              i_read;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic [31:0]       d_addr;
    logic              d_read;
    logic              d_write;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic [31:0]       bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [31:0]       bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;
    // The arbiter never looks at the returning address tag.
    modport master (
        input  i_addr, i_read, d_addr, d_read, d_write, d_wdata,
               bmem_ready, bmem_rdata, bmem_rvalid,
        output i_rdata, i_resp, d_rdata, d_resp,
               bmem_addr, bmem_read, bmem_write, bmem_wdata
    );
    modport slave (
        output i_addr, i_read, d_addr, d_read, d_write, d_wdata,
               bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  i_rdata, i_resp, d_rdata, d_resp,
               bmem_addr, bmem_read, bmem_write, bmem_wdata
    );
endinterface

// File: rtl/line_burst_buffer.sv
// line_burst_buffer: line register with a 2-bit beat index for burst assembly and slicing.
module line_burst_buffer
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [BEAT_W-1:0] beat_i,
    input  logic [LINE_W-1:0] src_i,
    output logic [LINE_W-1:0] line_o,
    output logic [1:0]        idx_o,
    output logic [BEAT_W-1:0] slice_o
);
    logic [LINE_W-1:0] line_q, line_d;
    logic [1:0]        idx_q, idx_d;

    always_comb begin
        line_d = line_q;
        if (load_i) line_d[{idx_q, 6'b0} +: BEAT_W] = beat_i;
        idx_d = clr_i ? 2'd0 : (load_i || step_i) ? idx_q + 2'd1 : idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
            idx_q  <= '0;
        end else begin
            line_q <= line_d;
            idx_q  <= idx_d;
        end
    end

    assign line_o  = line_q;
    assign idx_o   = idx_q;
    assign slice_o = src_i[{idx_q, 6'b0} +: BEAT_W];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin I/D cacheline arbiter onto a single 64-bit burst memory port.
module mem_arbiter
    import rv32i_types::*;
(
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);
    mem_arb_state_t    state_q, state_d;
    logic              prio_q, prio_d;
    logic              gnt_d_q, gnt_d_d;
    logic [31:0]       addr_q, addr_d, sel_addr;
    logic              pick_d, clr, load, step;
    logic [LINE_W-1:0] line;
    logic [1:0]        idx;
    logic [BEAT_W-1:0] slice;

    line_burst_buffer u_buf (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .load_i (load),
        .step_i (step),
        .beat_i (bus.bmem_rdata),
        .src_i  (bus.d_wdata),
        .line_o (line),
        .idx_o  (idx),
        .slice_o(slice)
    );

    // prio 0 favours D; a lone requester always wins.
    assign pick_d   = (bus.d_read | bus.d_write) & (~bus.i_read | ~prio_q);
    assign sel_addr = pick_d ? bus.d_addr : bus.i_addr;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        gnt_d_d = gnt_d_q;
        addr_d  = addr_q;
        clr     = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: if (bus.i_read | bus.d_read | bus.d_write) begin
                gnt_d_d = pick_d;
                prio_d  = pick_d;
                addr_d  = sel_addr & ~32'h1f;
                clr     = 1'b1;
                state_d = (pick_d & bus.d_write) ? WR_BURST : RD_REQ;
            end
            RD_REQ: if (bus.bmem_ready) begin
                clr     = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: if (bus.bmem_rvalid) begin
                load    = 1'b1;
                state_d = (idx == 2'd3) ? DONE : RD_WAIT;
            end
            WR_BURST: if (bus.bmem_ready) begin
                step    = 1'b1;
                state_d = (idx == 2'd3) ? DONE : WR_BURST;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            gnt_d_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            gnt_d_q <= gnt_d_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.i_rdata    = line;
    assign bus.d_rdata    = line;
    assign bus.i_resp     = (state_q == DONE) & ~gnt_d_q;
    assign bus.d_resp     = (state_q == DONE) & gnt_d_q;
    assign bus.bmem_read  = state_q == RD_REQ;
    assign bus.bmem_write = state_q == WR_BURST;
    assign bus.bmem_addr  = (state_q == RD_REQ || state_q == WR_BURST) ? addr_q : '0;
    assign bus.bmem_wdata = (state_q == WR_BURST) ? slice : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario checks for the I/D burst memory arbiter.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait memory: four beats base+0..base+3 follow an accepted read command.
    task automatic serve_read(input logic [63:0] base, output int n);
        int   pend;
        logic rd;
        pend = 0;
        n    = 0;
        bus.bmem_ready = 1'b1;
        while (!(bus.i_resp || bus.d_resp) && n < 30) begin
            bus.bmem_rvalid = pend > 0;
            bus.bmem_rdata  = base + 64'(4 - pend);
            rd = bus.bmem_read && bus.bmem_ready;
            step();
            n++;
            if (pend > 0) pend--;
            if (rd) pend = 4;
        end
        bus.bmem_rvalid = 1'b0;
        bus.bmem_rdata  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_addr = '0; bus.i_read = 0; bus.d_addr = '0; bus.d_read = 0; bus.d_write = 0;
        bus.d_wdata = '0; bus.bmem_ready = 0; bus.bmem_raddr = '0; bus.bmem_rdata = '0;
        bus.bmem_rvalid = 0;
        step();
        step();
        rst = 1'b0;
        step();
        checks++; if (bus.i_resp !== 1'b0) begin errors++; $display("FAIL reset_i_resp got=%0h exp=0", bus.i_resp); end
        checks++; if (bus.d_resp !== 1'b0) begin errors++; $display("FAIL reset_d_resp got=%0h exp=0", bus.d_resp); end
        checks++; if (bus.bmem_read !== 1'b0) begin errors++; $display("FAIL reset_bmem_read got=%0h exp=0", bus.bmem_read); end
        checks++; if (bus.bmem_write !== 1'b0) begin errors++; $display("FAIL reset_bmem_write got=%0h exp=0", bus.bmem_write); end
        checks++; if (bus.bmem_addr !== 32'h0) begin errors++; $display("FAIL reset_bmem_addr got=%0h exp=0", bus.bmem_addr); end
        checks++; if (bus.bmem_wdata !== 64'h0) begin errors++; $display("FAIL reset_bmem_wdata got=%0h exp=0", bus.bmem_wdata); end
        checks++; if (bus.i_rdata !== 256'h0) begin errors++; $display("FAIL reset_line got=%0h exp=0", bus.i_rdata); end
    endtask

    task automatic test_lone_iread();
        logic [63:0]  b [4];
        logic [255:0] exp_line;
        int           n;
        b[0] = 64'h1111111111111111; b[1] = 64'h2222222222222222;
        b[2] = 64'h3333333333333333; b[3] = 64'h4444444444444444;
        exp_line = {b[3], b[2], b[1], b[0]};
        bus.i_addr = 32'h0000_1234;
        bus.i_read = 1'b1;
        bus.bmem_ready = 1'b1;
        step();
        checks++; if (bus.bmem_read !== 1'b1 || bus.bmem_addr !== 32'h0000_1220) begin
            errors++; $display("FAIL iread_cmd read=%0h addr=%0h exp read=1 addr=00001220", bus.bmem_read, bus.bmem_addr);
        end
        step();
        for (int k = 0; k < 4; k++) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = b[k];
            bus.bmem_raddr  = 32'h0000_1220 + 32'(8 * k);
            checks++; if (bus.i_resp !== 1'b0) begin errors++; $display("FAIL iread_early_resp beat=%0d got=%0h exp=0", k, bus.i_resp); end
            step();
        end
        bus.bmem_rvalid = 1'b0;
        n = 0;
        checks++; if (bus.i_resp !== 1'b1) begin errors++; $display("FAIL iread_resp got=%0h exp=1", bus.i_resp); end
        checks++; if (bus.d_resp !== 1'b0) begin errors++; $display("FAIL iread_d_resp got=%0h exp=0", bus.d_resp); end
        checks++; if (bus.i_rdata !== exp_line) begin errors++; $display("FAIL iread_line got=%0h exp=%0h", bus.i_rdata, exp_line); end
        bus.i_read = 1'b0;
        step();
        checks++; if (bus.i_resp !== 1'b0) begin errors++; $display("FAIL iread_resp_pulse got=%0h exp=0", bus.i_resp); end
        step();
        checks++; if (bus.bmem_read !== 1'b0) begin errors++; $display("FAIL iread_no_regrant got=%0h exp=0", bus.bmem_read); end
        if (n != 0) $display("unexpected");
    endtask

    task automatic test_dwrite();
        logic [63:0] w [8];
        int          acc, n;
        logic        tog;
        foreach (w[k]) w[k] = '0;
        w[0] = 64'hD000_0000_0000_0A01; w[1] = 64'hD111_0000_0000_0B02;
        w[2] = 64'hD222_0000_0000_0C03; w[3] = 64'hD333_0000_0000_0D04;
        bus.d_addr  = 32'h0000_8040;
        bus.d_wdata = {w[3], w[2], w[1], w[0]};
        bus.d_write = 1'b1;
        bus.bmem_ready = 1'b1;
        step();
        acc = 0; n = 0; tog = 1'b1;
        while (!bus.d_resp && n < 20) begin
            bus.bmem_ready = tog;
            checks++; if (bus.bmem_write !== 1'b1 || bus.bmem_addr !== 32'h0000_8040 || bus.bmem_wdata !== w[acc]) begin
                errors++; $display("FAIL dwrite_beat cyc=%0d write=%0h addr=%0h wdata=%0h exp 1/00008040/%0h", n, bus.bmem_write, bus.bmem_addr, bus.bmem_wdata, w[acc]);
            end
            step();
            n++;
            if (tog) acc++;
            tog = ~tog;
        end
        checks++; if (acc != 4 || n != 7) begin errors++; $display("FAIL dwrite_count beats=%0d cycles=%0d exp 4/7", acc, n); end
        checks++; if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0) begin
            errors++; $display("FAIL dwrite_resp d=%0h i=%0h exp d=1 i=0", bus.d_resp, bus.i_resp);
        end
        bus.d_write = 1'b0;
        bus.bmem_ready = 1'b1;
        step();
        checks++; if (bus.d_resp !== 1'b0 || bus.bmem_write !== 1'b0) begin
            errors++; $display("FAIL dwrite_after resp=%0h write=%0h exp 0/0", bus.d_resp, bus.bmem_write);
        end
    endtask

    task automatic test_latency();
        int n;
        do_reset();
        bus.i_addr = 32'h0000_4000;
        bus.i_read = 1'b1;
        step();
        serve_read(64'h5000, n);
        // Request cycle counts as the first, so resp lands in the 7th cycle (6 edges later).
        checks++; if (n + 1 != 6 || bus.i_resp !== 1'b1) begin
            errors++; $display("FAIL latency edges=%0d resp=%0h exp edges=6 resp=1", n + 1, bus.i_resp);
        end
        bus.i_read = 1'b0;
        step();
    endtask

    task automatic test_contention();
        int n;
        do_reset();
        bus.i_addr = 32'h0000_0100; bus.d_addr = 32'h0000_0200;
        bus.i_read = 1'b1; bus.d_read = 1'b1;
        step();
        checks++; if (bus.bmem_addr !== 32'h200) begin errors++; $display("FAIL arb_r1_grant got=%0h exp=200", bus.bmem_addr); end
        serve_read(64'hA0, n);
        checks++; if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0) begin errors++; $display("FAIL arb_r1_resp d=%0h i=%0h exp 1/0", bus.d_resp, bus.i_resp); end
        checks++; if (bus.d_rdata !== {64'hA3, 64'hA2, 64'hA1, 64'hA0}) begin errors++; $display("FAIL arb_r1_line got=%0h", bus.d_rdata); end
        bus.d_read = 1'b0;
        step();
        step();
        checks++; if (bus.bmem_addr !== 32'h100) begin errors++; $display("FAIL arb_r2_grant got=%0h exp=100", bus.bmem_addr); end
        serve_read(64'hB0, n);
        checks++; if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0) begin errors++; $display("FAIL arb_r2_resp i=%0h d=%0h exp 1/0", bus.i_resp, bus.d_resp); end
        checks++; if (bus.i_rdata !== {64'hB3, 64'hB2, 64'hB1, 64'hB0}) begin errors++; $display("FAIL arb_r2_line got=%0h", bus.i_rdata); end
        bus.d_read = 1'b1;
        step();
        step();
        checks++; if (bus.bmem_addr !== 32'h200) begin errors++; $display("FAIL arb_r3_grant got=%0h exp=200", bus.bmem_addr); end
        serve_read(64'hC0, n);
        checks++; if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0) begin errors++; $display("FAIL arb_r3_resp d=%0h i=%0h exp 1/0", bus.d_resp, bus.i_resp); end
        bus.i_read = 1'b0; bus.d_read = 1'b0;
        step();
    endtask

    task automatic test_stray_rvalid();
        logic [255:0] held;
        int           n;
        held = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
        bus.bmem_rvalid = 1'b1;
        bus.bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        step(); step(); step();
        checks++; if (bus.bmem_read !== 1'b0 || bus.bmem_write !== 1'b0) begin
            errors++; $display("FAIL stray_idle read=%0h write=%0h exp 0/0", bus.bmem_read, bus.bmem_write);
        end
        checks++; if (bus.i_rdata !== held) begin errors++; $display("FAIL stray_idle_line got=%0h exp=%0h", bus.i_rdata, held); end
        bus.d_addr  = 32'h0000_9000;
        bus.d_wdata = {64'h4, 64'h3, 64'h2, 64'h1};
        bus.d_write = 1'b1;
        bus.bmem_ready = 1'b1;
        step();
        n = 0;
        while (!bus.d_resp && n < 20) begin step(); n++; end
        checks++; if (n != 4 || bus.d_rdata !== held) begin
            errors++; $display("FAIL stray_write cycles=%0d line=%0h exp 4/%0h", n, bus.d_rdata, held);
        end
        bus.d_write = 1'b0;
        bus.bmem_rvalid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        bus.i_addr = 32'h0000_3000;
        bus.i_read = 1'b1;
        bus.bmem_ready = 1'b1;
        step();
        step();
        bus.bmem_rvalid = 1'b1;
        bus.bmem_rdata = 64'h77; step();
        bus.bmem_rdata = 64'h88; step();
        rst = 1'b1;
        bus.i_read = 1'b0;
        bus.bmem_rdata = 64'h99;
        step();
        rst = 1'b0;
        checks++; if (bus.bmem_read !== 1'b0 || bus.bmem_addr !== 32'h0 || bus.i_rdata !== 256'h0) begin
            errors++; $display("FAIL rstmid_out read=%0h addr=%0h line=%0h exp all 0", bus.bmem_read, bus.bmem_addr, bus.i_rdata);
        end
        n = 0;
        for (int k = 0; k < 3; k++) begin
            if (bus.i_resp || bus.d_resp) n++;
            step();
        end
        checks++; if (n != 0 || bus.i_rdata !== 256'h0) begin
            errors++; $display("FAIL rstmid_noresp resps=%0d line=%0h exp 0/0", n, bus.i_rdata);
        end
        bus.bmem_rvalid = 1'b0;
        bus.i_read = 1'b1;
        step();
        checks++; if (bus.bmem_addr !== 32'h3000) begin errors++; $display("FAIL rstmid_regrant got=%0h exp=3000", bus.bmem_addr); end
        serve_read(64'hE0, n);
        checks++; if (bus.i_resp !== 1'b1 || bus.i_rdata !== {64'hE3, 64'hE2, 64'hE1, 64'hE0}) begin
            errors++; $display("FAIL rstmid_after resp=%0h line=%0h", bus.i_resp, bus.i_rdata);
        end
        bus.i_read = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_lone_iread();
        test_dwrite();
        test_latency();
        test_contention();
        test_stray_rvalid();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
